// File: rtl/vga_pkg.sv
// VGA timing defaults and decoder state encoding,
// shared by the timing generator and the receive decoder.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [9:0] sat_inc(
    input logic [9:0] v
  );
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchroniser for an async sync pin with a
// falling-edge detector sampled on the pixel tick.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic fall
);

  logic meta;
  logic level;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= raw;
      level <= meta;
      if (tick) prev <= level;
    end
  end

  assign fall = tick & prev & ~level;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: pixel position, data
// enable, line/frame period measurement and lock tracking.
module vga_sync_decoder #(
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int H_FP        = vga_pkg::H_FP,
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int V_FP        = vga_pkg::V_FP,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk100_in,
  input  logic       rstn_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic [7:0] rgb_in,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       de_out,
  output logic [7:0] rgb_out,
  output logic       locked_out,
  output logic       err_out,
  output logic [9:0] h_period_out,
  output logic [9:0] v_lines_out
);

  import vga_pkg::*;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO = 2 * H_TOTAL;
  localparam int TW = $clog2(TO + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] X_LOAD = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] Y_LOAD = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] X_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LEN  = 10'(H_TOTAL);
  localparam logic [9:0] V_LEN  = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [TW-1:0] TO_LAST = TW'(TO - 1);
  localparam logic [TW-1:0] TO_SAT  = TW'(TO);
  localparam logic [GW-1:0] G_LOCK  = GW'(LOCK_FRAMES);

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic          tick;
  logic          hs_fall;
  logic          vs_fall;
  logic [7:0]    rgb_m;
  logic [7:0]    rgb_s;

  logic [9:0]    x_n, y_n;
  logic [9:0]    hcnt, hcnt_n;
  logic [9:0]    vcnt, vcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] good_cnt, good_n;
  logic          bad_seen, bad_n;
  logic [9:0]    hp_n, vl_n;
  logic          de_n;
  logic [7:0]    rgb_n;
  logic          err_n;
  logic          line_ok;
  logic          frame_ok;
  logic          timeout;

  assign tick = (div == DIV_MAX);

  vga_sync_edge u_hs (
    .clk   (clk100_in),
    .rst_n (rstn_in),
    .tick  (tick),
    .raw   (hs_in),
    .fall  (hs_fall)
  );

  vga_sync_edge u_vs (
    .clk   (clk100_in),
    .rst_n (rstn_in),
    .tick  (tick),
    .raw   (vs_in),
    .fall  (vs_fall)
  );

  always_comb begin
    div_n    = tick ? '0 : div + DW'(1);
    state_n  = state;
    x_n      = x_out;
    y_n      = y_out;
    hcnt_n   = hcnt;
    vcnt_n   = vcnt;
    tcnt_n   = tcnt;
    good_n   = good_cnt;
    bad_n    = bad_seen;
    hp_n     = h_period_out;
    vl_n     = v_lines_out;
    de_n     = de_out;
    rgb_n    = rgb_out;
    err_n    = 1'b0;
    line_ok  = (hcnt == H_LEN);
    frame_ok = (vcnt == V_LEN) && !bad_seen;
    timeout  = tick && !hs_fall && (tcnt == TO_LAST);

    if (tick) begin
      if (hs_fall)
        x_n = X_LOAD;
      else if (x_out == X_MAX)
        x_n = '0;
      else
        x_n = x_out + 10'd1;

      if (vs_fall)
        y_n = Y_LOAD;
      else if (!hs_fall && x_out == X_MAX)
        y_n = (y_out == Y_MAX) ? '0 : y_out + 10'd1;

      if (hs_fall) begin
        hp_n   = hcnt;
        hcnt_n = 10'd1;
        tcnt_n = '0;
        vcnt_n = sat_inc(vcnt);
        if (!line_ok) bad_n = 1'b1;
      end else begin
        hcnt_n = sat_inc(hcnt);
        if (tcnt != TO_SAT) tcnt_n = tcnt + TW'(1);
      end

      // a line ending on the vs edge belongs to the new frame
      if (vs_fall) begin
        vl_n   = vcnt;
        vcnt_n = hs_fall ? 10'd1 : 10'd0;
        bad_n  = hs_fall && !line_ok;
      end

      unique case (state)
        SEARCH: begin
          if (vs_fall) begin
            state_n = TRACK;
            good_n  = '0;
          end
        end
        TRACK: begin
          if (vs_fall) begin
            if (frame_ok) begin
              good_n = good_cnt + GW'(1);
              if (good_n == G_LOCK) state_n = LOCKED;
            end else begin
              good_n = '0;
            end
          end
        end
        LOCKED: begin
          if ((hs_fall && !line_ok) ||
              (vs_fall && !frame_ok)) begin
            state_n = TRACK;
            good_n  = '0;
            err_n   = 1'b1;
          end
        end
        default: state_n = SEARCH;
      endcase

      if (timeout) begin
        state_n = SEARCH;
        good_n  = '0;
        err_n   = (state == LOCKED);
      end

      de_n  = (state_n == LOCKED) &&
              (x_n < H_ACT) && (y_n < V_ACT);
      rgb_n = de_n ? rgb_s : 8'h00;
    end
  end

  always_ff @(posedge clk100_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state        <= SEARCH;
      div          <= '0;
      rgb_m        <= '0;
      rgb_s        <= '0;
      x_out        <= '0;
      y_out        <= '0;
      hcnt         <= '0;
      vcnt         <= '0;
      tcnt         <= '0;
      good_cnt     <= '0;
      bad_seen     <= 1'b0;
      h_period_out <= '0;
      v_lines_out  <= '0;
      de_out       <= 1'b0;
      rgb_out      <= '0;
      locked_out   <= 1'b0;
      err_out      <= 1'b0;
    end else begin
      state        <= state_n;
      div          <= div_n;
      rgb_m        <= rgb_in;
      rgb_s        <= rgb_m;
      x_out        <= x_n;
      y_out        <= y_n;
      hcnt         <= hcnt_n;
      vcnt         <= vcnt_n;
      tcnt         <= tcnt_n;
      good_cnt     <= good_n;
      bad_seen     <= bad_n;
      h_period_out <= hp_n;
      v_lines_out  <= vl_n;
      de_out       <= de_n;
      rgb_out      <= rgb_n;
      locked_out   <= (state_n == LOCKED);
      err_out      <= err_n;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder driven by a small
// scaled-down VGA timing model.
module tb_vga_sync_decoder;

  localparam int CLK_DIV     = 2;
  localparam int H_ACTIVE    = 8;
  localparam int H_FP        = 2;
  localparam int H_SYNC      = 2;
  localparam int H_TOTAL     = 16;
  localparam int V_ACTIVE    = 6;
  localparam int V_FP        = 1;
  localparam int V_SYNC      = 1;
  localparam int V_TOTAL     = 10;
  localparam int LOCK_FRAMES = 2;
  localparam int FRAME_CYC   = H_TOTAL * V_TOTAL * CLK_DIV;
  localparam int LIMIT       = 8 * FRAME_CYC;

  logic       clk = 1'b0;
  logic       rstn_in;
  logic       hs_in;
  logic       vs_in;
  logic [7:0] rgb_in;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic       de_out;
  logic [7:0] rgb_out;
  logic       locked_out;
  logic       err_out;
  logic [9:0] h_period_out;
  logic [9:0] v_lines_out;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int err_cnt     = 0;

  int gx, gy;
  int vs_falls;
  int gen_vs_cyc;
  int h_req, h_done;
  int drop_req, drop_done;
  bit hold;
  bit gen_on;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (err_out === 1'b1) err_cnt <= err_cnt + 1;

  vga_sync_decoder #(
    .CLK_DIV     (CLK_DIV),
    .H_ACTIVE    (H_ACTIVE),
    .H_FP        (H_FP),
    .H_TOTAL     (H_TOTAL),
    .V_ACTIVE    (V_ACTIVE),
    .V_FP        (V_FP),
    .V_TOTAL     (V_TOTAL),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) dut (
    .clk100_in    (clk),
    .rstn_in      (rstn_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .rgb_in       (rgb_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .de_out       (de_out),
    .rgb_out      (rgb_out),
    .locked_out   (locked_out),
    .err_out      (err_out),
    .h_period_out (h_period_out),
    .v_lines_out  (v_lines_out)
  );

  // timing model: one pixel per CLK_DIV clocks
  initial begin
    logic nvs;
    int   hlen, vlen;
    hs_in = 1'b1;
    vs_in = 1'b1;
    rgb_in = 8'h00;
    gx = 0;
    gy = 0;
    vs_falls = 0;
    gen_vs_cyc = 0;
    h_done = 0;
    drop_done = 0;
    wait (gen_on);
    forever begin
      repeat (CLK_DIV) @(posedge clk);
      #1;
      if (hold) begin
        hs_in = 1'b1;
        vs_in = 1'b1;
        rgb_in = 8'h00;
      end else begin
        hs_in = !(gx >= H_ACTIVE + H_FP &&
                  gx < H_ACTIVE + H_FP + H_SYNC);
        nvs = !(gy >= V_ACTIVE + V_FP &&
                gy < V_ACTIVE + V_FP + V_SYNC);
        if (vs_in && !nvs) begin
          vs_falls++;
          gen_vs_cyc = cyc;
        end
        vs_in = nvs;
        rgb_in = (gx < H_ACTIVE && gy < V_ACTIVE) ?
                 {1'b1, 3'(gy), 4'(gx)} : 8'h00;
        hlen = (h_req != h_done) ? H_TOTAL + 1 : H_TOTAL;
        gx++;
        if (gx == hlen) begin
          gx = 0;
          h_done = h_req;
          vlen = (drop_req != drop_done) ?
                 V_TOTAL - 1 : V_TOTAL;
          gy++;
          if (gy == vlen) begin
            gy = 0;
            drop_done = drop_req;
          end
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d required %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wait_lock(input string tag);
    for (int i = 0; i < LIMIT && locked_out !== 1'b1; i++)
      @(negedge clk);
    check(tag, 32'(locked_out), 32'd1);
  endtask

  task automatic wait_err(input string tag);
    for (int i = 0; i < LIMIT && err_out !== 1'b1; i++)
      @(negedge clk);
    check(tag, 32'(err_out), 32'd1);
  endtask

  task automatic wait_gy(input int row);
    for (int i = 0; i < LIMIT && gy != row; i++)
      @(negedge clk);
  endtask

  initial begin
    int base;
    int e0;
    int lat;
    int hi;
    int rises;
    int run;
    logic pd;
    rstn_in = 1'b0;
    hold = 1'b0;
    h_req = 0;
    drop_req = 0;
    gen_on = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_x", 32'(x_out), 32'd0);
    check("rst_y", 32'(y_out), 32'd0);
    check("rst_de", 32'(de_out), 32'd0);
    check("rst_rgb", 32'(rgb_out), 32'd0);
    check("rst_locked", 32'(locked_out), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_hper", 32'(h_period_out), 32'd0);
    check("rst_vlines", 32'(v_lines_out), 32'd0);

    rstn_in = 1'b1;
    @(negedge clk);
    gen_on = 1'b1;

    wait_lock("acq_lock");
    lat = cyc - gen_vs_cyc;
    check("acq_vs_falls", 32'(vs_falls), 32'd3);
    check("acq_latency",
          32'(lat >= 3 && lat <= CLK_DIV + 2), 32'd1);
    check("acq_hper", 32'(h_period_out), 32'(H_TOTAL));
    check("acq_vlines", 32'(v_lines_out), 32'(V_TOTAL));
    check("acq_no_err", 32'(err_cnt), 32'd0);

    for (int i = 0; i < LIMIT && y_out != 10'(V_TOTAL - 1); i++)
      @(negedge clk);
    for (int i = 0; i < LIMIT && de_out !== 1'b1; i++)
      @(negedge clk);
    check("first_x", 32'(x_out), 32'd0);
    check("first_y", 32'(y_out), 32'd0);
    check("first_rgb", 32'(rgb_out), 32'h80);

    hi = 0;
    rises = 0;
    pd = 1'b0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (de_out === 1'b1) hi++;
      if (de_out === 1'b1 && !pd) rises++;
      pd = de_out;
      @(negedge clk);
    end
    check("de_cycles_frame", 32'(hi),
          32'(H_ACTIVE * V_ACTIVE * CLK_DIV));
    check("de_lines_frame", 32'(rises), 32'(V_ACTIVE));

    for (int i = 0; i < LIMIT && de_out !== 1'b0; i++)
      @(negedge clk);
    for (int i = 0; i < LIMIT && de_out !== 1'b1; i++)
      @(negedge clk);
    run = 0;
    for (int i = 0; i < LIMIT && de_out === 1'b1; i++) begin
      run++;
      @(negedge clk);
    end
    check("de_run_line", 32'(run), 32'(H_ACTIVE * CLK_DIV));

    for (int i = 0; i < LIMIT &&
         !(x_out == 10'd3 && y_out == 10'd2); i++)
      @(negedge clk);
    check("pix32_rgb", 32'(rgb_out), 32'ha3);
    check("pix32_de", 32'(de_out), 32'd1);

    e0 = err_cnt;
    wait_gy(2);
    h_req++;
    wait_err("stretch_err");
    check("stretch_unlock", 32'(locked_out), 32'd0);
    check("stretch_hper", 32'(h_period_out), 32'(H_TOTAL + 1));
    base = vs_falls;
    wait_lock("stretch_relock");
    check("stretch_relock_vs", 32'(vs_falls - base), 32'd3);
    check("stretch_one_err", 32'(err_cnt), 32'(e0 + 1));

    e0 = err_cnt;
    wait_gy(0);
    drop_req++;
    wait_err("drop_err");
    check("drop_vlines", 32'(v_lines_out), 32'(V_TOTAL - 1));
    check("drop_unlock", 32'(locked_out), 32'd0);
    check("drop_hper", 32'(h_period_out), 32'(H_TOTAL));
    base = vs_falls;
    wait_lock("drop_relock");
    check("drop_relock_vs", 32'(vs_falls - base), 32'd2);
    check("drop_one_err", 32'(err_cnt), 32'(e0 + 1));

    wait_gy(3);
    e0 = err_cnt;
    hold = 1'b1;
    repeat (3 * H_TOTAL * CLK_DIV) @(negedge clk);
    check("to_err", 32'(err_cnt), 32'(e0 + 1));
    check("to_unlock", 32'(locked_out), 32'd0);
    hold = 1'b0;
    base = vs_falls;
    wait_lock("to_relock");
    check("to_relock_vs", 32'(vs_falls - base), 32'd3);

    for (int i = 0; i < LIMIT && de_out !== 1'b1; i++)
      @(negedge clk);
    check("pre_rst_locked", 32'(locked_out), 32'd1);
    @(posedge clk);
    #2;
    rstn_in = 1'b0;
    #1;
    check("arst_x", 32'(x_out), 32'd0);
    check("arst_y", 32'(y_out), 32'd0);
    check("arst_de", 32'(de_out), 32'd0);
    check("arst_rgb", 32'(rgb_out), 32'd0);
    check("arst_locked", 32'(locked_out), 32'd0);
    check("arst_hper", 32'(h_period_out), 32'd0);
    check("arst_vlines", 32'(v_lines_out), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rstn_in = 1'b1;
    base = vs_falls;
    wait_lock("rst_relock");
    check("rst_relock_vs", 32'(vs_falls - base), 32'd3);
    check("rst_relock_hper", 32'(h_period_out), 32'(H_TOTAL));
    check("rst_relock_vlines", 32'(v_lines_out), 32'(V_TOTAL));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
